// File: rtl/event_id_gen_mc.sv
// rtl/event_id_gen_mc.sv - event ID generator with ID FIFO, wrap modes and AXI4-Lite control
//
// Purpose: assigns an advancing event ID to each rising edge of trig_in while enabled,
// buffers the IDs in a FIFO and delivers them on a valid/ready stream. Configuration,
// status and drop/trigger counters are accessed through an AXI4-Lite slave.
//
// Ports:
//   ACLK, ARESET                 clock, asynchronous active-high reset
//   trig_in                      trigger level (synchronous to ACLK)
//   m_id_tdata/tvalid/tready     event ID stream out
//   s_axi_aw*/w*/b*              AXI4-Lite write channels
//   s_axi_ar*/r*                 AXI4-Lite read channels
module event_id_gen_mc #(
    parameter int ID_WIDTH           = 16,
    parameter int FIFO_DEPTH         = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          trig_in,
    output logic [ID_WIDTH-1:0]           m_id_tdata,
    output logic                          m_id_tvalid,
    input  logic                          m_id_tready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ID_WIDTH-1:0] ID_ONES = '1;

    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_CTRL   = C_S_AXI_ADDR_WIDTH'(8'h00);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_PRESET = C_S_AXI_ADDR_WIDTH'(8'h04);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_WMAX   = C_S_AXI_ADDR_WIDTH'(8'h08);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_NEXT   = C_S_AXI_ADDR_WIDTH'(8'h0C);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_STATUS = C_S_AXI_ADDR_WIDTH'(8'h10);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_DROP   = C_S_AXI_ADDR_WIDTH'(8'h14);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_TRIG   = C_S_AXI_ADDR_WIDTH'(8'h18);

    logic                ctrl_enable;
    logic                ctrl_wrap_mode;
    logic [ID_WIDTH-1:0] id_preset;
    logic [ID_WIDTH-1:0] wrap_max;
    logic [ID_WIDTH-1:0] id_next;
    logic                overflow;
    logic [31:0]         drop_count;
    logic [31:0]         trig_count;
    logic                trig_q;

    logic [ID_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;

    logic                wr_fire;
    logic                rd_fire;
    logic                trig_event;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                wr_ctrl_b0;
    logic                do_load;
    logic                do_clr;
    logic [ID_WIDTH-1:0] wrap_limit;
    logic [ID_WIDTH-1:0] id_adv;
    logic [31:0]         rd_mux;

    // Byte-strobe merge of a write into a 32-bit register image.
    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign wr_fire    = s_axi_awvalid & s_axi_awready & s_axi_wvalid & s_axi_wready;
    assign rd_fire    = s_axi_arvalid & s_axi_arready;
    assign trig_event = trig_in & ~trig_q & ctrl_enable;
    // Full is taken from the registered level, so a same-cycle pop cannot rescue a push.
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push       = trig_event & ~fifo_full;
    assign pop        = m_id_tvalid & m_id_tready;
    assign wr_ctrl_b0 = wr_fire & (s_axi_awaddr == ADDR_CTRL) & s_axi_wstrb[0];
    assign do_load    = wr_ctrl_b0 & s_axi_wdata[2];
    assign do_clr     = wr_ctrl_b0 & s_axi_wdata[3];
    assign wrap_limit = ctrl_wrap_mode ? wrap_max : ID_ONES;
    // An ID above WRAP_MAX never matches the limit, so it runs on to all-ones and rolls over.
    assign id_adv     = (id_next == wrap_limit) ? '0 : id_next + ID_WIDTH'(1);

    assign m_id_tvalid = (fifo_count != '0);
    assign m_id_tdata  = m_id_tvalid ? mem[rd_ptr] : '0;
    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= id_next;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_enable    <= 1'b0;
            ctrl_wrap_mode <= 1'b0;
            id_preset      <= '0;
            wrap_max       <= '1;
            id_next        <= '0;
            overflow       <= 1'b0;
            drop_count     <= '0;
            trig_count     <= '0;
            trig_q         <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
        end else begin
            trig_q <= trig_in;

            if (wr_fire) begin
                case (s_axi_awaddr)
                    ADDR_CTRL: begin
                        if (s_axi_wstrb[0]) begin
                            ctrl_enable    <= s_axi_wdata[0];
                            ctrl_wrap_mode <= s_axi_wdata[1];
                        end
                    end
                    ADDR_PRESET: id_preset <= ID_WIDTH'(merge_strb(32'(id_preset), s_axi_wdata, s_axi_wstrb));
                    ADDR_WMAX:   wrap_max  <= ID_WIDTH'(merge_strb(32'(wrap_max), s_axi_wdata, s_axi_wstrb));
                    default: ;
                endcase
            end

            // A same-edge event has already pushed the old ID; load overrides the advance.
            if (do_load) begin
                id_next <= id_preset;
            end else if (trig_event) begin
                id_next <= id_adv;
            end

            if (do_clr) begin
                trig_count <= '0;
                drop_count <= '0;
                overflow   <= 1'b0;
            end else if (trig_event) begin
                if (trig_count != '1) trig_count <= trig_count + 32'd1;
                if (fifo_full) begin
                    overflow <= 1'b1;
                    if (drop_count != '1) drop_count <= drop_count + 32'd1;
                end
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Write channel: AW and W are taken together, one transaction in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_awready & ~s_axi_bvalid;
            s_axi_wready  <= s_axi_awvalid & s_axi_wvalid & ~s_axi_awready & ~s_axi_bvalid;
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (s_axi_araddr)
            ADDR_CTRL:   rd_mux = {30'd0, ctrl_wrap_mode, ctrl_enable};
            ADDR_PRESET: rd_mux = 32'(id_preset);
            ADDR_WMAX:   rd_mux = 32'(wrap_max);
            ADDR_NEXT:   rd_mux = 32'(id_next);
            ADDR_STATUS: rd_mux = {15'd0, overflow, 16'(fifo_count)};
            ADDR_DROP:   rd_mux = drop_count;
            ADDR_TRIG:   rd_mux = trig_count;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= s_axi_arvalid & ~s_axi_arready & ~s_axi_rvalid;
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule
